ram_port_master: RTL and testbench

- Initiator-side engine for the on-chip single-port RAM port: 12-bit word address, 4-bit byte enable, 32-bit data, one-cycle registered read latency.
- Accepts block commands (write N words / read N words from a start address) and converts them into per-cycle RAM accesses.
- Write data comes from a valid/ready input stream; read data leaves on a valid/ready output stream with full backpressure support.
- Sits between a loader or DMA front-end and the RamOnChip instance.

---
 rtl/ram_port_master.sv | 143 ++++++++++++++
 tb/tb_ram_port_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_master.sv
// Block-transfer engine for a single-port RAM with one-cycle read latency.
// Write words stream in via valid/ready; read words leave through a 2-entry skid FIFO.
module ram_port_master #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_write_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [AW:0]     cmd_len_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  input  logic [DW/8-1:0] wbe_i,
  output logic            rdat_valid_o,
  input  logic            rdat_ready_i,
  output logic [DW-1:0]   rdat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            ram_we_o,
  output logic [AW-1:0]   ram_adr_o,
  output logic [DW/8-1:0] ram_be_o,
  output logic [DW-1:0]   ram_dat_o,
  input  logic [DW-1:0]   ram_dat_i
);

  localparam logic [AW-1:0] AdrOne = 1;
  localparam logic [AW:0]   RemOne = 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [AW:0]     rem_q, rem_d;
  logic            done_q, done_d;
  logic            inflight_q;
  logic [DW-1:0]   fifo_q [2];
  logic            rd_ptr_q, wr_ptr_q;
  logic [1:0]      cnt_q;
  logic            pop, issue, wr_hs;
  logic [1:0]      occ;

  assign pop   = (cnt_q != 2'd0) && rdat_ready_i;
  assign wr_hs = (state_q == StWrite) && wdat_valid_i;
  // Words held after this edge (buffered plus in flight); counting the pop keeps 1 word/cycle.
  assign occ   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue = (state_q == StRead) && (occ < 2'd2);

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          adr_d = cmd_adr_i;
          rem_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = cmd_write_i ? StWrite : StRead;
          end
        end
      end
      StWrite: begin
        if (wdat_valid_i) begin
          adr_d = adr_q + AdrOne;
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        if (issue) begin
          adr_d = adr_q + AdrOne;
          rem_d = rem_q - RemOne;
          if (rem_q == RemOne) state_d = StDrain;
        end
      end
      StDrain: begin
        if (occ == 2'd0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      inflight_q <= issue;
    end
  end

  // Skid FIFO: capture the RAM word the cycle after each issued read.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= ram_dat_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

  always_comb begin
    cmd_ready_o  = rst_n_i && (state_q == StIdle);
    wdat_ready_o = (state_q == StWrite);
    busy_o       = (state_q != StIdle);
    done_o       = done_q;
    rdat_valid_o = (cnt_q != 2'd0);
    rdat_o       = rdat_valid_o ? fifo_q[rd_ptr_q] : '0;
    ram_we_o     = wr_hs;
    ram_adr_o    = ((state_q == StWrite) || issue) ? adr_q : '0;
    ram_be_o     = (state_q == StWrite) ? wbe_i : '0;
    ram_dat_o    = (state_q == StWrite) ? wdat_i : '0;
  end

endmodule

// File: tb/tb_ram_port_master.sv
// Randomized and directed bench for ram_port_master with a word-level reference model.
module tb_ram_port_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_adr = '0;
  logic [12:0] cmd_len = '0;
  logic        wdat_valid = 1'b0, wdat_ready;
  logic [31:0] wdat = '0;
  logic [3:0]  wbe = '0;
  logic        rdat_valid, rdat_ready = 1'b0;
  logic [31:0] rdat;
  logic        busy, done, ram_we;
  logic [11:0] ram_adr;
  logic [3:0]  ram_be;
  logic [31:0] ram_dat_o, ram_dat_i;

  ram_port_master #(.AW(12), .DW(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready), .wdat_i(wdat), .wbe_i(wbe),
    .rdat_valid_o(rdat_valid), .rdat_ready_i(rdat_ready), .rdat_o(rdat),
    .busy_o(busy), .done_o(done), .ram_we_o(ram_we), .ram_adr_o(ram_adr),
    .ram_be_o(ram_be), .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Environment RAM (what the DUT really drives) and golden RAM (what it should hold).
  logic [31:0] ram  [4096];
  logic [31:0] gold [4096];

  always @(posedge clk) begin
    if (ram_we) ram[ram_adr] <= merge(ram[ram_adr], ram_dat_o, ram_be);
    ram_dat_i <= ram[ram_adr];
  end

  // Reference model state
  int          cyc = 0;
  bit          m_busy, m_write, m_done;
  logic [11:0] m_adr, m_radr;
  int          m_left, m_rleft;
  int          done_cnt = 0;
  int          acc_edge, first_lat = -1;
  bit          want_first;
  logic [31:0] rd_got [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs_zero",
          {cmd_ready, wdat_ready, rdat_valid, busy, done, ram_we, ram_adr, ram_be},
          '0);
      chk("reset_data_zero", {rdat, ram_dat_o}, '0);
      m_busy = 0; m_write = 0; m_done = 0; m_left = 0; m_rleft = 0; want_first = 0;
    end else begin
      bit nd;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (done) done_cnt++;
      if (m_busy && m_write) begin
        chk("wdat_ready", wdat_ready, 1'b1);
        chk("ram_we", ram_we, wdat_valid);
        if (wdat_valid) chk("ram_wr", {ram_adr, ram_be, ram_dat_o}, {m_adr, wbe, wdat});
      end else begin
        chk("ram_we_idle", ram_we, 1'b0);
      end
      if (m_rleft == 0) chk("rdat_spurious", rdat_valid, 1'b0);
      if (rdat_valid && want_first) begin
        first_lat  = cyc - acc_edge;
        want_first = 0;
      end
      nd = 0;
      if (cmd_valid && cmd_ready) begin
        if (cmd_len == 0) nd = 1;
        else begin
          m_busy = 1; m_write = cmd_write; m_adr = cmd_adr; m_left = int'(cmd_len);
          if (!cmd_write) begin
            m_radr = cmd_adr; m_rleft = int'(cmd_len);
            acc_edge = cyc + 1; want_first = 1;
          end
        end
      end else if (m_busy && m_write && wdat_valid) begin
        gold[m_adr] = merge(gold[m_adr], wdat, wbe);
        m_adr++;
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_write = 0; nd = 1; end
      end
      if (m_rleft > 0 && rdat_valid && rdat_ready) begin
        chk("rdat", rdat, gold[m_radr]);
        rd_got.push_back(rdat);
        m_radr++;
        m_rleft--;
        if (m_rleft == 0) begin m_busy = 0; nd = 1; end
      end
      m_done = nd;
    end
  end

  logic [31:0] wq_d [$];
  logic [3:0]  wq_b [$];

  task automatic send_cmd(input bit w, input logic [11:0] adr, input logic [12:0] len);
    int g;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_write = w; cmd_adr = adr; cmd_len = len;
    g = 0;
    do begin @(negedge clk); g++; end while (!cmd_ready && g < 50);
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic feed_words();
    int i, g;
    i = 0; g = 0;
    while (i < wq_d.size() && g < 4000) begin
      wdat_valid = ($urandom_range(0, 3) != 0);
      wdat = wq_d[i]; wbe = wq_b[i];
      @(negedge clk);
      if (wdat_valid && wdat_ready) i++;
      g++;
      @(posedge clk); #1;
    end
    wdat_valid = 0;
    chk("feed_count", i, wq_d.size());
  endtask

  task automatic wait_done(input int d0, input int mode, input int max);
    int k;
    k = 0;
    while (done_cnt == d0 && k < max) begin
      case (mode)
        0: rdat_ready = 1;
        1: rdat_ready = (k % 3 == 0);
        default: rdat_ready = $urandom_range(0, 1);
      endcase
      @(negedge clk);
      k++;
      @(posedge clk); #1;
    end
    rdat_ready = 0;
    repeat (2) @(posedge clk);
    #1 chk("done_once", done_cnt, d0 + 1);
  endtask

  task automatic do_write(input logic [11:0] adr);
    int d0;
    d0 = done_cnt;
    send_cmd(1'b1, adr, 13'(wq_d.size()));
    feed_words();
    wait_done(d0, 0, 200);
  endtask

  task automatic do_read(input logic [11:0] adr, input int len, input int mode);
    int d0;
    d0 = done_cnt;
    rd_got.delete();
    send_cmd(1'b0, adr, 13'(len));
    wait_done(d0, mode, 4 * len + 50);
    chk("read_count", rd_got.size(), len);
  endtask

  initial begin
    int d0, mode, len;
    logic [11:0] adr;
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = $urandom;
      gold[i] = ram[i];
    end
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("post_reset", {cmd_ready, busy, rdat_valid, done}, 4'b1000);

    // Write then read four words
    wq_d = '{32'h2401000C, 32'h2402000D, 32'h2403000E, 32'h004C180B};
    wq_b = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(12'h000);
    do_read(12'h000, 4, 0);
    chk("first_rdat_latency", first_lat, 2);
    if (rd_got.size() == 4) begin
      chk("wr_rd_w0", rd_got[0], 32'h2401000C);
      chk("wr_rd_w3", rd_got[3], 32'h004C180B);
    end

    // Byte enables
    wq_d = '{32'hAABBCCDD}; wq_b = '{4'hF};
    do_write(12'h005);
    wq_d = '{32'h11223344}; wq_b = '{4'b0101};
    do_write(12'h005);
    do_read(12'h005, 1, 0);
    if (rd_got.size() == 1) chk("byte_enable", rd_got[0], 32'hAA22CC44);

    // Backpressure pattern 1,0,0,...
    do_read(12'h100, 8, 1);

    // Address wrap
    wq_d = '{32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003}; wq_b = '{4'hF, 4'hF, 4'hF};
    do_write(12'hFFE);
    chk("wrap_ram_ffe", ram[12'hFFE], 32'hCAFE0001);
    chk("wrap_ram_fff", ram[12'hFFF], 32'hCAFE0002);
    chk("wrap_ram_000", ram[12'h000], 32'hCAFE0003);
    do_read(12'hFFE, 3, 2);
    if (rd_got.size() == 3) chk("wrap_read_last", rd_got[2], 32'hCAFE0003);

    // Zero length: done the cycle after accept, no RAM access
    d0 = done_cnt;
    send_cmd(1'b1, 12'h123, 13'd0);
    @(negedge clk);
    chk("len0_done", {done, busy, ram_we}, 3'b100);
    @(negedge clk);
    chk("len0_done_clear", done, 1'b0);

    // Whole RAM read
    do_read(12'h7A0, 4096, 2);

    // Random traffic
    for (int t = 0; t < 24; t++) begin
      adr  = 12'($urandom);
      len  = $urandom_range(1, 24);
      mode = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        wq_d.delete(); wq_b.delete();
        for (int i = 0; i < len; i++) begin
          wq_d.push_back($urandom);
          wq_b.push_back(4'($urandom));
        end
        do_write(adr);
      end else begin
        do_read(adr, len, mode);
      end
    end

    // Reset in the middle of an 8-word read
    rd_got.delete();
    send_cmd(1'b0, 12'h040, 13'd8);
    rdat_ready = 1;
    for (int k = 0; k < 40 && rd_got.size() < 3; k++) @(negedge clk);
    chk("pre_reset_words", rd_got.size(), 3);
    @(posedge clk); #1;
    rst_n = 0;
    #1 chk("midreset_zero", {cmd_ready, rdat_valid, busy, done, ram_we, rdat}, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    d0 = done_cnt;
    @(negedge clk);
    chk("after_reset", {cmd_ready, rdat_valid, busy}, 3'b100);
    repeat (5) @(negedge clk);
    chk("no_done_after_reset", done_cnt, d0);
    rdat_ready = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
